// File: rtl/uart_io_regs.sv
// uart_io_regs: memory-mapped UART register block.
// Sits between the CPU IO port and the uart core's stream interfaces. TX and RX
// bytes are buffered in FIFOs, overflow errors are held in sticky flags, and a
// level interrupt is raised for RX data available and/or TX fully drained.
module uart_io_regs #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        io_read_valid_i,
    input  logic        io_write_valid_i,
    input  logic [11:0] io_addr_i,
    input  logic [31:0] io_wdata_i,
    output logic [31:0] io_rdata_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_busy_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        irq_o
);

    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int TX_LW = TX_PW + 1;
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int RX_LW = RX_PW + 1;

    localparam logic [9:0] WORD_DATA   = 10'h000;
    localparam logic [9:0] WORD_RXDATA = 10'h002;
    localparam logic [9:0] WORD_CTRL   = 10'h003;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GUARD
    } tx_state_e;

    // Storage and state
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [TX_PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [RX_PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [TX_LW-1:0] tx_level_q, tx_level_d;
    logic [RX_LW-1:0] rx_level_q, rx_level_d;
    tx_state_e        tx_state_q, tx_state_d;
    logic             rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
    logic             rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;

    // Decoded strobes and derived status
    logic [9:0]  word_addr;
    logic        wr_txdata, wr_ctrl, rd_status, rd_rxdata, flush;
    logic        tx_full, tx_empty, tx_push, tx_pop, tx_idle;
    logic        rx_full, rx_empty, rx_push, rx_pop;
    logic [31:0] status_word, rxdata_word;
    logic        unused_ok;

    assign unused_ok  = ^{io_addr_i[1:0], io_wdata_i[31:8]};
    assign rx_ready_o = rx_valid_i;
    assign io_rdata_o = rdata_q;
    assign irq_o      = irq_q;

    // Address decode and FIFO handshakes; full is judged before any same-cycle pop
    // for TX, while an RXDATA pop frees a slot for a same-cycle RX push.
    always_comb begin
        word_addr = io_addr_i[11:2];
        wr_txdata = io_write_valid_i && (word_addr == WORD_DATA);
        wr_ctrl   = io_write_valid_i && (word_addr == WORD_CTRL);
        rd_status = io_read_valid_i && (word_addr == WORD_DATA);
        rd_rxdata = io_read_valid_i && (word_addr == WORD_RXDATA);
        flush     = wr_ctrl && io_wdata_i[2];

        tx_full   = (tx_level_q == TX_LW'(TX_DEPTH));
        tx_empty  = (tx_level_q == '0);
        tx_push   = wr_txdata && !tx_full;
        tx_pop    = (tx_state_q == TX_SEND) && !tx_empty;
        tx_idle   = tx_empty && (tx_state_q == TX_IDLE) && !tx_busy_i;

        rx_full   = (rx_level_q == RX_LW'(RX_DEPTH));
        rx_empty  = (rx_level_q == '0);
        rx_pop    = rd_rxdata && !rx_empty;
        rx_push   = rx_valid_i && (!rx_full || rx_pop);

        status_word = {8'h00, 8'(rx_level_q), 8'(tx_level_q), 3'b000,
                       tx_ovf_q, rx_ovf_q, tx_idle, !rx_empty, tx_full};
        rxdata_word = rx_empty ? 32'h0 : {23'h0, 1'b1, rx_mem[rx_rd_ptr_q]};
    end

    // FIFO pointer and level bookkeeping; flush wins over any same-cycle push/pop.
    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_level_d  = tx_level_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_level_d  = rx_level_q;
        if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + TX_PW'(1);
        if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + TX_PW'(1);
        if (tx_push && !tx_pop) tx_level_d = tx_level_q + TX_LW'(1);
        if (!tx_push && tx_pop) tx_level_d = tx_level_q - TX_LW'(1);
        if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + RX_PW'(1);
        if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + RX_PW'(1);
        if (rx_push && !rx_pop) rx_level_d = rx_level_q + RX_LW'(1);
        if (!rx_push && rx_pop) rx_level_d = rx_level_q - RX_LW'(1);
        if (flush) begin
            tx_wr_ptr_d = '0;
            tx_rd_ptr_d = '0;
            tx_level_d  = '0;
            rx_wr_ptr_d = '0;
            rx_rd_ptr_d = '0;
            rx_level_d  = '0;
        end
    end

    // TX drain sequencer next state: start only when idle with data and the uart free,
    // then a one-cycle guard so the uart has time to raise its busy flag.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty && !tx_busy_i) tx_state_d = TX_SEND;
            end
            TX_SEND: begin
                tx_valid_o = 1'b1;
                tx_data_o  = tx_mem[tx_rd_ptr_q];
                tx_state_d = TX_GUARD;
            end
            TX_GUARD: begin
                tx_state_d = TX_IDLE;
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // Register file, sticky flags, read-data capture and interrupt next values.
    always_comb begin
        rdata_d  = rdata_q;
        rx_ie_d  = rx_ie_q;
        tx_ie_d  = tx_ie_q;
        rx_ovf_d = rx_ovf_q;
        tx_ovf_d = tx_ovf_q;
        if (io_read_valid_i) begin
            case (word_addr)
                WORD_DATA:   rdata_d = status_word;
                WORD_RXDATA: rdata_d = rxdata_word;
                WORD_CTRL:   rdata_d = {30'h0, tx_ie_q, rx_ie_q};
                default:     rdata_d = 32'h0;
            endcase
        end
        if (rd_status) begin
            rx_ovf_d = 1'b0;
            tx_ovf_d = 1'b0;
        end
        if (rx_valid_i && rx_full && !rx_pop) rx_ovf_d = 1'b1;
        if (wr_txdata && tx_full) tx_ovf_d = 1'b1;
        if (wr_ctrl) begin
            rx_ie_d = io_wdata_i[0];
            tx_ie_d = io_wdata_i[1];
        end
        irq_d = (rx_ie_q && !rx_empty) || (tx_ie_q && tx_idle);
    end

    // FIFO data arrays carry no reset; only the pointers define their contents.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_ptr_q] <= io_wdata_i[7:0];
        if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data_i;
    end

    // State register for pointers, levels, sequencer, control and outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_level_q  <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_level_q  <= '0;
            tx_state_q  <= TX_IDLE;
            rx_ie_q     <= 1'b0;
            tx_ie_q     <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            rdata_q     <= 32'h0;
            irq_q       <= 1'b0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_level_q  <= tx_level_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_level_q  <= rx_level_d;
            tx_state_q  <= tx_state_d;
            rx_ie_q     <= rx_ie_d;
            tx_ie_q     <= tx_ie_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_ovf_q    <= tx_ovf_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

endmodule

// File: tb/tb_uart_io_regs.sv
// tb_uart_io_regs: directed scenarios plus randomized traffic against a
// queue-based model of the UART register block.
module tb_uart_io_regs;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        io_rv, io_wv;
    logic [11:0] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        irq;

    logic        force_busy;
    int          uart_cnt;
    logic [7:0]  seen[$];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign tx_busy = force_busy | (uart_cnt != 0);

    uart_io_regs #(.TX_DEPTH(D), .RX_DEPTH(D)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .io_read_valid_i(io_rv), .io_write_valid_i(io_wv),
        .io_addr_i(io_addr), .io_wdata_i(io_wdata), .io_rdata_o(io_rdata),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_busy_i(tx_busy),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .irq_o(irq)
    );

    // Uart transmitter stand-in: busy for 10 cycles after each accepted byte.
    always @(posedge clk) begin
        if (tx_valid) uart_cnt <= 10;
        else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
    end

    // Log every byte handed to the uart.
    always @(posedge clk) begin
        if (tx_valid) seen.push_back(tx_data);
    end

    // Reference model state
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    bit          m_rx_ovf, m_tx_ovf, m_rx_ie, m_tx_ie;
    int          m_phase;
    logic [31:0] exp_rdata;
    bit          exp_irq;

    // Behavioural model: every rule evaluated on the pre-edge state, then applied.
    always @(posedge clk or negedge rst_n) begin : model
        int txn, rxn;
        logic [9:0] w;
        bit idle_now, tpop, tpush, rpop, rpush, rovf, tovf, fl;
        if (!rst_n) begin
            txq.delete();
            rxq.delete();
            m_rx_ovf = 0; m_tx_ovf = 0; m_rx_ie = 0; m_tx_ie = 0;
            m_phase = 0;
            exp_rdata = 32'h0;
            exp_irq = 0;
        end else begin
            txn = txq.size();
            rxn = rxq.size();
            w = io_addr[11:2];
            idle_now = (txn == 0) && (m_phase == 0) && !tx_busy;
            if (io_rv) begin
                if (w == 10'd0)
                    exp_rdata = {8'h00, 8'(rxn), 8'(txn), 3'b000, m_tx_ovf, m_rx_ovf,
                                 idle_now, rxn > 0, txn == D};
                else if (w == 10'd2)
                    exp_rdata = (rxn > 0) ? {23'h0, 1'b1, rxq[0]} : 32'h0;
                else if (w == 10'd3)
                    exp_rdata = {30'h0, m_tx_ie, m_rx_ie};
                else
                    exp_rdata = 32'h0;
            end
            exp_irq = (m_rx_ie && rxn > 0) || (m_tx_ie && idle_now);
            tpop  = (m_phase == 1) && (txn > 0);
            tpush = io_wv && (w == 10'd0) && (txn < D);
            tovf  = io_wv && (w == 10'd0) && (txn == D);
            rpop  = io_rv && (w == 10'd2) && (rxn > 0);
            rpush = rx_valid && ((rxn < D) || rpop);
            rovf  = rx_valid && (rxn == D) && !rpop;
            fl    = io_wv && (w == 10'd3) && io_wdata[2];
            if (m_phase == 0) m_phase = (txn > 0 && !tx_busy) ? 1 : 0;
            else if (m_phase == 1) m_phase = 2;
            else m_phase = 0;
            if (io_rv && w == 10'd0) begin
                m_rx_ovf = 0;
                m_tx_ovf = 0;
            end
            if (rovf) m_rx_ovf = 1;
            if (tovf) m_tx_ovf = 1;
            if (io_wv && w == 10'd3) begin
                m_rx_ie = io_wdata[0];
                m_tx_ie = io_wdata[1];
            end
            if (tpop)  void'(txq.pop_front());
            if (tpush) txq.push_back(io_wdata[7:0]);
            if (rpop)  void'(rxq.pop_front());
            if (rpush) rxq.push_back(rx_data);
            if (fl) begin
                txq.delete();
                rxq.delete();
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("rdata", io_rdata, exp_rdata);
            checkOutput("tx_valid", 32'(tx_valid), 32'(m_phase == 1));
            if (tx_valid && m_phase == 1 && txq.size() > 0)
                checkOutput("tx_data", 32'(tx_data), 32'(txq[0]));
            checkOutput("irq", 32'(irq), 32'(exp_irq));
            checkOutput("rx_ready", 32'(rx_ready), 32'(rx_valid));
            checkOutput("tx_valid_while_busy", 32'(tx_valid & tx_busy), 32'h0);
        end
    end

    // Drive one cycle of IO/RX inputs shortly after the falling edge.
    task automatic applyStimulus(input logic rv, input logic wv, input logic [11:0] addr,
                                 input logic [31:0] wdata, input logic rxv, input logic [7:0] rxd);
        @(negedge clk);
        #1;
        io_rv = rv; io_wv = wv; io_addr = addr; io_wdata = wdata;
        rx_valid = rxv; rx_data = rxd;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 12'h0, 32'h0, 0, 8'h0);
    endtask

    task automatic ioWrite(input logic [11:0] addr, input logic [31:0] data);
        applyStimulus(0, 1, addr, data, 0, 8'h0);
        idleCycles(1);
    endtask

    task automatic ioRead(input logic [11:0] addr);
        applyStimulus(1, 0, addr, 32'h0, 0, 8'h0);
        idleCycles(1);
    endtask

    task automatic rxPush(input logic [7:0] b);
        applyStimulus(0, 0, 12'h0, 32'h0, 1, b);
        idleCycles(1);
    endtask

    logic [7:0]  exp1[3] = '{8'h41, 8'h42, 8'h43};
    logic [11:0] raddrs[6] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h800};

    initial begin
        bit found;
        int op;
        rst_n = 0; force_busy = 0;
        io_rv = 0; io_wv = 0; io_addr = 0; io_wdata = 0; rx_valid = 0; rx_data = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset_rdata", io_rdata, 32'h0);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        checkOutput("reset_tx_valid", 32'(tx_valid), 32'h0);
        checkOutput("reset_tx_data", 32'(tx_data), 32'h0);
        #1 rst_n = 1;
        idleCycles(3);

        $display("[TB] scenario 1: three TX bytes paced by uart busy");
        seen.delete();
        ioWrite(12'h000, 32'h41);
        ioWrite(12'h000, 32'h42);
        ioWrite(12'h000, 32'h43);
        idleCycles(60);
        checkOutput("t1_count", 32'(seen.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < seen.size()) checkOutput("t1_byte", 32'(seen[i]), 32'(exp1[i]));

        $display("[TB] scenario 2: TX overflow with uart held busy");
        force_busy = 1;
        for (int i = 0; i < 17; i++) ioWrite(12'h000, 32'(8'h60 + i));
        ioRead(12'h000);
        checkOutput("t2_status_ovf", io_rdata, 32'h0000_1011);
        ioRead(12'h000);
        checkOutput("t2_status_clr", io_rdata, 32'h0000_1001);
        force_busy = 0;
        idleCycles(400);

        $display("[TB] scenario 3: single RX byte");
        rxPush(8'h5A);
        ioRead(12'h000);
        checkOutput("t3_status_lvl1", io_rdata, 32'h0001_0006);
        ioRead(12'h008);
        checkOutput("t3_rxdata", io_rdata, 32'h0000_015A);
        ioRead(12'h008);
        checkOutput("t3_rxdata_empty", io_rdata, 32'h0);
        ioRead(12'h000);
        checkOutput("t3_status_lvl0", io_rdata, 32'h0000_0004);

        $display("[TB] scenario 4: RX overflow and pop-frees-slot");
        for (int i = 0; i < 16; i++) rxPush(8'(i + 1));
        rxPush(8'hEE);
        ioRead(12'h000);
        checkOutput("t4_status_ovf", io_rdata, 32'h0010_000E);
        applyStimulus(1, 0, 12'h008, 32'h0, 1, 8'h77);
        idleCycles(1);
        checkOutput("t4_rxdata_head", io_rdata, 32'h0000_0101);
        ioRead(12'h000);
        checkOutput("t4_status_noovf", io_rdata, 32'h0010_0006);
        ioWrite(12'h00C, 32'h4);
        ioRead(12'h000);
        checkOutput("t4_status_flushed", io_rdata, 32'h0000_0004);
        ioRead(12'h00C);
        checkOutput("t4_ctrl_after_flush", io_rdata, 32'h0);

        $display("[TB] scenario 5: interrupt enables");
        ioWrite(12'h00C, 32'h1);
        rxPush(8'h33);
        idleCycles(1);
        checkOutput("t5_irq_rx", 32'(irq), 32'h1);
        ioRead(12'h008);
        idleCycles(1);
        checkOutput("t5_irq_rx_clear", 32'(irq), 32'h0);
        ioWrite(12'h00C, 32'h2);
        idleCycles(1);
        checkOutput("t5_irq_tx_idle", 32'(irq), 32'h1);

        $display("[TB] scenario 6: reset during SEND");
        idleCycles(20);
        ioWrite(12'h000, 32'h99);
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            #1;
            if (tx_valid) found = 1;
        end
        checkOutput("t6_send_seen", 32'(found), 32'h1);
        rst_n = 0;
        #1;
        checkOutput("t6_valid_drop", 32'(tx_valid), 32'h0);
        checkOutput("t6_data_drop", 32'(tx_data), 32'h0);
        checkOutput("t6_irq_drop", 32'(irq), 32'h0);
        @(negedge clk);
        #1 rst_n = 1;
        idleCycles(2);
        ioRead(12'h000);
        checkOutput("t6_status", io_rdata, 32'h0000_0004);
        ioRead(12'h00C);
        checkOutput("t6_ctrl", io_rdata, 32'h0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 1500; n++) begin
            logic rxv;
            logic [11:0] ra;
            logic [31:0] wd;
            op  = $urandom_range(0, 9);
            rxv = ($urandom_range(0, 2) == 0);
            ra  = raddrs[$urandom_range(0, 5)] | 12'($urandom_range(0, 3));
            wd  = $urandom;
            case (op)
                0, 1, 2: applyStimulus(0, 1, 12'h000, wd, rxv, 8'($urandom));
                3: begin
                    wd[2] = ($urandom_range(0, 19) == 0);
                    applyStimulus(0, 1, 12'h00C, wd, rxv, 8'($urandom));
                end
                4, 5, 6: applyStimulus(1, 0, ra, wd, rxv, 8'($urandom));
                7: applyStimulus(1, 1, 12'h000, wd, rxv, 8'($urandom));
                default: applyStimulus(0, 0, 12'h000, wd, rxv, 8'($urandom));
            endcase
        end
        idleCycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
